// File: rtl/psr_branch_unit.sv
// psr_branch_unit: program status register {C,L,F,Z,N} with masked ALU
// flag updates and PSR load/store. It also contains a two-state branch
// resolver that gives a registered taken/not-taken decision one cycle
// after each accepted request.
module psr_branch_unit #(
    parameter int REGBITS  = 5,
    parameter int WIDTH    = 16,
    parameter int CONDBITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic [REGBITS-1:0]  PSRwrite,
    input  logic                psr_wen,
    input  logic [REGBITS-1:0]  psr_mask,
    input  logic                psr_load,
    input  logic [WIDTH-1:0]    psr_din,
    output logic [WIDTH-1:0]    psr_out,
    output logic [REGBITS-1:0]  flags,
    input  logic                br_valid,
    input  logic [CONDBITS-1:0] br_cond,
    input  logic                br_flush,
    output logic                br_done,
    output logic                br_taken
);

    // Flag positions inside the PSR
    localparam int C_BIT = 4;
    localparam int L_BIT = 3;
    localparam int F_BIT = 2;
    localparam int Z_BIT = 1;
    localparam int N_BIT = 0;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_RESOLVED = 1'b1
    } state_t;

    state_t               state_q;
    logic [REGBITS-1:0]   psr_q;
    logic [REGBITS-1:0]   psr_d;
    logic                 br_taken_q;
    logic                 br_taken_d;
    logic                 accept_s;

    // The upper bits of the load source are intentionally ignored
    logic                 unused_din_s;
    assign unused_din_s = ^psr_din[WIDTH-1:REGBITS];

    // Evaluate a condition code against a flag vector
    function automatic logic eval_cond(input logic [REGBITS-1:0] p,
                                       input logic [CONDBITS-1:0] cc);
        logic r;
        case (cc)
            4'b0000: r = p[Z_BIT];
            4'b0001: r = ~p[Z_BIT];
            4'b0010: r = p[C_BIT];
            4'b0011: r = ~p[C_BIT];
            4'b0100: r = p[L_BIT];
            4'b0101: r = ~p[L_BIT];
            4'b0110: r = p[N_BIT];
            4'b0111: r = ~p[N_BIT];
            4'b1000: r = p[F_BIT];
            4'b1001: r = ~p[F_BIT];
            4'b1010: r = ~p[L_BIT] & ~p[Z_BIT];
            4'b1011: r = p[L_BIT] | p[Z_BIT];
            4'b1100: r = ~p[N_BIT] & ~p[Z_BIT];
            4'b1101: r = p[N_BIT] | p[Z_BIT];
            4'b1110: r = 1'b1;
            4'b1111: r = 1'b0;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Next PSR value: load has priority over a masked ALU flag commit
    always_comb begin
        psr_d = psr_q;
        if (stall) begin
            psr_d = psr_q;
        end else if (psr_load) begin
            psr_d = psr_din[REGBITS-1:0];
        end else if (psr_wen) begin
            psr_d = (psr_q & ~psr_mask) | (PSRwrite & psr_mask);
        end else begin
            psr_d = psr_q;
        end
    end

    // Branches see the bypassed next-state flags, so a compare and its
    // dependent branch can share a cycle
    assign accept_s   = br_valid & ~stall & ~br_flush;
    assign br_taken_d = eval_cond(psr_d, br_cond);

    // PSR register and branch decision state machine
    always_ff @(posedge clk) begin
        if (reset) begin
            psr_q      <= {REGBITS{1'b0}};
            state_q    <= ST_IDLE;
            br_taken_q <= 1'b0;
        end else if (stall) begin
            psr_q      <= psr_q;
            state_q    <= state_q;
            br_taken_q <= br_taken_q;
        end else begin
            psr_q <= psr_d;
            if (accept_s) begin
                state_q    <= ST_RESOLVED;
                br_taken_q <= br_taken_d;
            end else begin
                state_q    <= ST_IDLE;
                br_taken_q <= 1'b0;
            end
        end
    end

    // Architectural reads see only the registered PSR
    assign flags    = psr_q;
    assign psr_out  = {{(WIDTH-REGBITS){1'b0}}, psr_q};
    assign br_done  = (state_q == ST_RESOLVED);
    assign br_taken = br_taken_q;

endmodule

// File: tb/tb_psr_branch_unit.sv
// Directed testbench for psr_branch_unit with hand-computed expectations.
module tb_psr_branch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [4:0]  PSRwrite;
    logic        psr_wen;
    logic [4:0]  psr_mask;
    logic        psr_load;
    logic [15:0] psr_din;
    logic [15:0] psr_out;
    logic [4:0]  flags;
    logic        br_valid;
    logic [3:0]  br_cond;
    logic        br_flush;
    logic        br_done;
    logic        br_taken;

    int checks;
    int failures;

    psr_branch_unit #(.REGBITS(5), .WIDTH(16), .CONDBITS(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .PSRwrite (PSRwrite),
        .psr_wen  (psr_wen),
        .psr_mask (psr_mask),
        .psr_load (psr_load),
        .psr_din  (psr_din),
        .psr_out  (psr_out),
        .flags    (flags),
        .br_valid (br_valid),
        .br_cond  (br_cond),
        .br_flush (br_flush),
        .br_done  (br_done),
        .br_taken (br_taken)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [15:0] got,
                            input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall    = 1'b0;
        PSRwrite = 5'b00000;
        psr_wen  = 1'b0;
        psr_mask = 5'b00000;
        psr_load = 1'b0;
        psr_din  = 16'h0000;
        br_valid = 1'b0;
        br_cond  = 4'b0000;
        br_flush = 1'b0;
    endtask

    // Directed condition vectors: loaded PSR, condition, expected taken
    logic [4:0] vec_psr  [12] = '{5'b10000, 5'b10000, 5'b00001, 5'b00001,
                                  5'b00100, 5'b00000, 5'b00000, 5'b00010,
                                  5'b00010, 5'b00000, 5'b01000, 5'b00010};
    logic [3:0] vec_cond [12] = '{4'b0010, 4'b0011, 4'b0110, 4'b0111,
                                  4'b1000, 4'b1001, 4'b1100, 4'b1100,
                                  4'b1101, 4'b0101, 4'b0100, 4'b0001};
    logic       vec_exp  [12] = '{1'b1, 1'b0, 1'b1, 1'b0,
                                  1'b1, 1'b1, 1'b1, 1'b0,
                                  1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        checks   = 0;
        failures = 0;
        idle_inputs();
        reset = 1'b1;
        psr_wen = 1'b1; psr_mask = 5'b11111; PSRwrite = 5'b11111;
        br_valid = 1'b1; br_cond = 4'b1110;
        tick();
        check_eq("rst_flags", {11'd0, flags}, 16'h0000);
        check_eq("rst_psr_out", psr_out, 16'h0000);
        check_eq("rst_done", {15'd0, br_done}, 16'h0000);
        check_eq("rst_taken", {15'd0, br_taken}, 16'h0000);
        reset = 1'b0;
        idle_inputs();

        // Full write; SPR in the write cycle still sees the old value
        psr_wen = 1'b1; psr_mask = 5'b11111; PSRwrite = 5'b10101;
        #1;
        check_eq("spr_old", psr_out, 16'h0000);
        tick();
        check_eq("wr_flags", {11'd0, flags}, 16'h0015);
        check_eq("wr_psr_out", psr_out, 16'h0015);

        // Masked write clears only Z
        PSRwrite = 5'b11111;
        tick();
        psr_mask = 5'b00010; PSRwrite = 5'b00000;
        tick();
        check_eq("mask_z", {11'd0, flags}, 16'h001D);

        // Zero mask is no write
        psr_mask = 5'b00000;
        tick();
        check_eq("mask_zero", {11'd0, flags}, 16'h001D);

        // Stall holds the PSR
        stall = 1'b1; psr_mask = 5'b11111; PSRwrite = 5'b00000;
        tick();
        check_eq("stall_psr", {11'd0, flags}, 16'h001D);
        stall = 1'b0;

        // Bypass: write Z=1 and branch EQ in the same cycle
        psr_mask = 5'b11111; PSRwrite = 5'b00010;
        br_valid = 1'b1; br_cond = 4'b0000;
        tick();
        check_eq("byp_done", {15'd0, br_done}, 16'h0001);
        check_eq("byp_taken", {15'd0, br_taken}, 16'h0001);
        check_eq("byp_flags", {11'd0, flags}, 16'h0002);
        idle_inputs();
        tick();
        check_eq("idle_done", {15'd0, br_done}, 16'h0000);
        check_eq("idle_taken", {15'd0, br_taken}, 16'h0000);

        // Load beats write and ignores upper bits
        psr_load = 1'b1; psr_din = 16'hFFE0;
        psr_wen = 1'b1; psr_mask = 5'b11111; PSRwrite = 5'b11111;
        tick();
        check_eq("load_wins", {11'd0, flags}, 16'h0000);
        idle_inputs();

        // Condition table, back-to-back, using load bypass each cycle
        for (int i = 0; i < 12; i++) begin
            psr_load = 1'b1; psr_din = {11'd0, vec_psr[i]};
            br_valid = 1'b1; br_cond = vec_cond[i];
            tick();
            check_eq($sformatf("cond%0d_done", i), {15'd0, br_done}, 16'h0001);
            check_eq($sformatf("cond%0d_taken", i), {15'd0, br_taken},
                     {15'd0, vec_exp[i]});
        end
        idle_inputs();

        // L=1: HS, LO, UN back-to-back, then stall on the last decision
        psr_wen = 1'b1; psr_mask = 5'b11111; PSRwrite = 5'b01000;
        tick();
        idle_inputs();
        br_valid = 1'b1; br_cond = 4'b1011;
        tick();
        check_eq("b2b_hs_done", {15'd0, br_done}, 16'h0001);
        check_eq("b2b_hs_taken", {15'd0, br_taken}, 16'h0001);
        br_cond = 4'b1010;
        tick();
        check_eq("b2b_lo_done", {15'd0, br_done}, 16'h0001);
        check_eq("b2b_lo_taken", {15'd0, br_taken}, 16'h0000);
        br_cond = 4'b1111;
        tick();
        check_eq("b2b_un_done", {15'd0, br_done}, 16'h0001);
        check_eq("b2b_un_taken", {15'd0, br_taken}, 16'h0000);
        stall = 1'b1; br_cond = 4'b1110;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq($sformatf("stall%0d_done", i), {15'd0, br_done}, 16'h0001);
            check_eq($sformatf("stall%0d_taken", i), {15'd0, br_taken}, 16'h0000);
        end
        idle_inputs();
        tick();
        check_eq("post_stall_done", {15'd0, br_done}, 16'h0000);

        // Flush from IDLE drops the request but not the PSR write
        br_valid = 1'b1; br_flush = 1'b1; br_cond = 4'b1110;
        psr_wen = 1'b1; psr_mask = 5'b11111; PSRwrite = 5'b00001;
        tick();
        check_eq("flush_done", {15'd0, br_done}, 16'h0000);
        check_eq("flush_psr", {11'd0, flags}, 16'h0001);
        idle_inputs();

        // Flush while RESOLVED returns to IDLE
        br_valid = 1'b1; br_cond = 4'b1110;
        tick();
        check_eq("pre_flush_done", {15'd0, br_done}, 16'h0001);
        br_flush = 1'b1;
        tick();
        check_eq("flush_res_done", {15'd0, br_done}, 16'h0000);
        idle_inputs();

        // Reset in RESOLVED loses the pending decision
        br_valid = 1'b1; br_cond = 4'b1110;
        tick();
        check_eq("pre_rst_taken", {15'd0, br_taken}, 16'h0001);
        reset = 1'b1;
        tick();
        check_eq("rst_res_done", {15'd0, br_done}, 16'h0000);
        check_eq("rst_res_taken", {15'd0, br_taken}, 16'h0000);
        check_eq("rst_res_flags", {11'd0, flags}, 16'h0000);
        reset = 1'b0;
        idle_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
